// File: rtl/npu_config_decoder.sv
// NPU configuration word decoder: pops header/payload packets from the
// config FIFO and drives state-machine register loads and weight writes.
module npu_config_decoder #(
  parameter int DATA_WIDTH  = 16,
  parameter int WADDR_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  cfg_fifo_data,
  input  logic                   cfg_fifo_empty,
  output logic                   cfg_fifo_read_en,
  input  logic                   npu_state_config,
  output logic [DATA_WIDTH-1:0]  npu_state_data_in,
  output logic                   npu_state_input_reg_enable,
  output logic                   npu_state_output_reg_enable,
  output logic                   weight_wr_en,
  output logic [WADDR_WIDTH-1:0] weight_wr_addr,
  output logic [DATA_WIDTH-1:0]  weight_wr_data,
  output logic                   cfg_busy,
  output logic                   cfg_error
);

  typedef enum logic [1:0] {
    HDR = 2'd0,
    P1  = 2'd1,
    PW  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    T_IN    = 2'd0,
    T_OUT   = 2'd1,
    T_WADDR = 2'd2
  } tgt_t;

  localparam logic [WADDR_WIDTH-1:0] PTR_ONE = 1;

  state_t                 state_q, state_d;
  tgt_t                   tgt_q, tgt_d;
  logic [11:0]            rem_q, rem_d;
  logic [WADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                   rd_pending;

  logic                   err_d;
  logic                   in_en_d, out_en_d, wr_en_d;
  logic [DATA_WIDTH-1:0]  data_d, wdata_d;
  logic [WADDR_WIDTH-1:0] waddr_d;

  logic [3:0]             op;
  logic [11:0]            len;

  assign op  = cfg_fifo_data[DATA_WIDTH-1 -: 4];
  assign len = cfg_fifo_data[11:0];

  assign cfg_fifo_read_en = npu_state_config & ~cfg_fifo_empty;
  assign cfg_busy = (state_q != HDR) | rd_pending;

  // Decode the word that arrived this cycle; outputs default to holding.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    rem_d    = rem_q;
    ptr_d    = ptr_q;
    err_d    = cfg_error;
    in_en_d  = 1'b0;
    out_en_d = 1'b0;
    wr_en_d  = 1'b0;
    data_d   = npu_state_data_in;
    waddr_d  = weight_wr_addr;
    wdata_d  = weight_wr_data;
    if (rd_pending) begin
      unique case (state_q)
        HDR: begin
          unique case (op)
            4'h0: begin
              state_d = HDR;
            end
            4'h1: begin
              state_d = P1;
              tgt_d   = T_IN;
            end
            4'h2: begin
              state_d = P1;
              tgt_d   = T_OUT;
            end
            4'h3: begin
              state_d = P1;
              tgt_d   = T_WADDR;
            end
            4'h4: begin
              if (len != 12'd0) begin
                state_d = PW;
                rem_d   = len;
              end
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
        P1: begin
          state_d = HDR;
          unique case (tgt_q)
            T_IN: begin
              in_en_d = 1'b1;
              data_d  = cfg_fifo_data;
            end
            T_OUT: begin
              out_en_d = 1'b1;
              data_d   = cfg_fifo_data;
            end
            default: begin
              ptr_d = cfg_fifo_data[WADDR_WIDTH-1:0];
            end
          endcase
        end
        PW: begin
          wr_en_d = 1'b1;
          waddr_d = ptr_q;
          wdata_d = cfg_fifo_data;
          ptr_d   = ptr_q + PTR_ONE;
          rem_d   = rem_q - 12'd1;
          if (rem_q == 12'd1) state_d = HDR;
        end
        default: begin
          state_d = HDR;
        end
      endcase
    end
  end

  // State, pointer and registered outputs; reset abandons any packet.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q                     <= HDR;
      tgt_q                       <= T_IN;
      rem_q                       <= '0;
      ptr_q                       <= '0;
      rd_pending                  <= 1'b0;
      cfg_error                   <= 1'b0;
      npu_state_input_reg_enable  <= 1'b0;
      npu_state_output_reg_enable <= 1'b0;
      weight_wr_en                <= 1'b0;
      npu_state_data_in           <= '0;
      weight_wr_addr              <= '0;
      weight_wr_data              <= '0;
    end else begin
      state_q                     <= state_d;
      tgt_q                       <= tgt_d;
      rem_q                       <= rem_d;
      ptr_q                       <= ptr_d;
      rd_pending                  <= cfg_fifo_read_en;
      cfg_error                   <= err_d;
      npu_state_input_reg_enable  <= in_en_d;
      npu_state_output_reg_enable <= out_en_d;
      weight_wr_en                <= wr_en_d;
      npu_state_data_in           <= data_d;
      weight_wr_addr              <= waddr_d;
      weight_wr_data              <= wdata_d;
    end
  end

endmodule
